user_ram_ctrl: RTL and testbench
================================

# user_ram_ctrl

Parametrised single-port user RAM for SoC-side scratch storage, successor to the fixed 32-bit user RAM. It adds configurable data width and depth, per-byte write enables, a registered read with a valid strobe, and a hardware clear sequencer. The sequencer zeroes the array after reset and on request, so the storage itself carries no reset and can map to block RAM. It sits behind the bus adapter as a slave memory, with optional per-byte parity checking.

## Interface
- `ADDR_BIT`, default 8: address width; depth `DEPTH = 2**ADDR_BIT` words (localparam).
- `DATA_BIT`, default 32: word width; must be a multiple of 8; `BE_BIT = DATA_BIT/8`.
- `IDLE_VAL`, default `{{DATA_BIT-1{1'b0}},1'b1}`: value driven on `do_o` when no read data is valid.
- `clk_i`, in, 1: single clock, rising-edge.
- `rst_i`, in, 1: reset, asynchronous, active-low.
- `wr_en_i`, in, 1: write request.
- `rd_en_i`, in, 1: read request.
- `be_i`, in, BE_BIT: byte enables for writes; bit k gates `di_i[8k+7:8k]`.
- `addr_i`, in, ADDR_BIT: word address.
- `di_i`, in, DATA_BIT: write data.
- `clr_i`, in, 1: single-cycle request to zero the whole array.
- `do_o`, out, DATA_BIT: read data.
- `rd_valid_o`, out, 1: `do_o` holds read data this cycle.
- `busy_o`, out, 1: clear in progress; requests are ignored.
- `par_err_o`, out, 1: parity mismatch on the current read data.

## Operation
- FSM states: CLEAR and IDLE.
- Reset (`rst_i`=0):
  - state = CLEAR, clear counter = 0.
  - `busy_o`=1, `rd_valid_o`=0, `par_err_o`=0, `do_o`=IDLE_VAL.
  - Array contents are undefined until the clear completes.
- CLEAR:
  - Each cycle writes all-zero, with zero parity, at the counter address, then increments the counter.
  - After the write to DEPTH-1, go to IDLE; the counter wraps to 0.
  - `wr_en_i`, `rd_en_i` and `clr_i` are ignored.
- IDLE:
  - `clr_i`=1: go to CLEAR with the counter at 0. Any same-cycle write or read is dropped.
  - Otherwise, `wr_en_i`=1: for each k with `be_i[k]`=1, byte k at `addr_i` takes the new data; other bytes keep their values.
  - Otherwise, `rd_en_i`=1: read accepted.
- Simultaneous `wr_en_i` and `rd_en_i`: write wins; no read occurs and `rd_valid_o` stays 0.
- A write with `be_i`=0 is a no-op but still blocks a same-cycle read.
- Reset asserted mid-clear: restart from address 0 on release.
- Read data register: holds its last value. `do_o = rd_valid_o ? rdata : IDLE_VAL`.

## Timing
- Read latency: 1 cycle. A read accepted at edge N gives `rd_valid_o`=1 and data at `do_o` after edge N, for exactly one cycle per accepted read.
- Back-to-back reads: one per cycle, full throughput.
- Read-after-write to the same address on the next cycle returns the new data.
- Clear duration: DEPTH cycles. After reset release, `busy_o` is 1 for the first DEPTH edges and falls after edge DEPTH.
- After a `clr_i` at edge N, `busy_o` rises after N and falls after edge N+DEPTH.
- `par_err_o` is aligned with `rd_valid_o` and is 0 whenever `rd_valid_o`=0.

## Configuration
- `USER_RAM_PARITY_EN` defined:
  - Stores one even-parity bit per byte, written alongside each enabled byte.
  - On each read, recomputes parity and sets `par_err_o`=1 with `rd_valid_o` if any byte mismatches.
- Not defined: no parity storage or logic; `par_err_o` is tied to 0.

## Structure
- Package `user_ram_pkg`:
  - FSM state enum (CLEAR, IDLE).
  - Default IDLE_VAL constant.
  - Byte-parity function.
- Sub-module `user_ram_clr_seq`: the FSM plus clear counter. It outputs the clear address, clear write enable and `busy_o`, and takes `clr_i`.
- The top holds the array, byte-enable merge, read register and the parity option.

## Test plan
- Reset release with DEPTH=256, then poll `busy_o` → `busy_o` falls after 256 edges; a read of any address returns 0 and `rd_valid_o`=1 for one cycle.
- Write `32'hDEADBEEF` to addr 5 with `be_i`=4'hF, then a write with `be_i`=4'b0010 and `di_i`=`32'h00001100`, then read addr 5 → `do_o`=`32'hDEADBEEF` before the partial write and `32'hDEAD11EF` after it; latency 1 cycle.
- `wr_en_i` and `rd_en_i` together on addr 3 with data `32'h12345678` → `rd_valid_o` stays 0; a read the next cycle returns `32'h12345678`.
- Pulse `clr_i` with a write in the same cycle, then reset asserted mid-clear at count 100 → both requests are ignored; after reset release, `busy_o` stays high for a full 256 cycles and all words read 0.
- With `USER_RAM_PARITY_EN`, force one stored data bit of addr 7 to flip, then read addr 7 → `par_err_o`=1 coincident with `rd_valid_o`. Reads of other addresses → `par_err_o`=0.
- Idle, with no accepted read → `do_o`=IDLE_VAL (`32'h1`) and `rd_valid_o`=0.

Source files
------------

// File: rtl/user_ram_pkg.sv
// Shared types, constants and helpers for the user RAM controller.
// USER_RAM_PARITY_EN (see user_ram_ctrl) uses byte_parity for per-byte check bits.
package user_ram_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } ram_state_t;

  localparam int unsigned IDLE_VAL_DEF = 1;

  // Even parity: stored bit makes the byte plus parity have an even count of ones.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/user_ram_clr_seq.sv
// Clear sequencer: walks every address writing zero after reset and on clr_i.
// Requests arriving at the top are ignored while busy_o is high.
module user_ram_clr_seq
  import user_ram_pkg::*;
#(
  parameter int unsigned ADDR_BIT = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  output logic [ADDR_BIT-1:0] clr_addr_o,
  output logic                clr_we_o,
  output logic                busy_o
);

  ram_state_t          r_state;
  logic [ADDR_BIT-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          // Counter wraps to zero on the final address, ready for the next clear.
          r_cnt <= r_cnt + ADDR_BIT'(1);
          if (&r_cnt) r_state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (clr_i) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
          end
        end
        default: r_state <= ST_CLEAR;
      endcase
    end
  end

  assign clr_addr_o = r_cnt;
  assign clr_we_o   = (r_state == ST_CLEAR);
  assign busy_o     = (r_state == ST_CLEAR);

endmodule

// File: rtl/user_ram_ctrl.sv
// Parametrised single-port user RAM with byte enables, registered read and clear sequencer.
// Define USER_RAM_PARITY_EN to add per-byte even parity storage and read checking.
module user_ram_ctrl
  import user_ram_pkg::*;
#(
  parameter int unsigned          ADDR_BIT = 8,
  parameter int unsigned          DATA_BIT = 32,
  parameter logic [DATA_BIT-1:0]  IDLE_VAL = DATA_BIT'(IDLE_VAL_DEF)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic                  rd_en_i,
  input  logic [DATA_BIT/8-1:0] be_i,
  input  logic [ADDR_BIT-1:0]   addr_i,
  input  logic [DATA_BIT-1:0]   di_i,
  input  logic                  clr_i,
  output logic [DATA_BIT-1:0]   do_o,
  output logic                  rd_valid_o,
  output logic                  busy_o,
  output logic                  par_err_o
);

  localparam int unsigned DEPTH  = 2**ADDR_BIT;
  localparam int unsigned BE_BIT = DATA_BIT/8;

  logic [ADDR_BIT-1:0] w_clr_addr;
  logic                w_clr_we;
  logic                w_busy;
  logic                w_wr;
  logic                w_rd;

  logic [DATA_BIT-1:0] r_mem [DEPTH];
  logic [DATA_BIT-1:0] r_rdata;
  logic                r_rd_valid;

  user_ram_clr_seq #(
    .ADDR_BIT (ADDR_BIT)
  ) u_clr_seq (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (clr_i),
    .clr_addr_o (w_clr_addr),
    .clr_we_o   (w_clr_we),
    .busy_o     (w_busy)
  );

  // clr_i outranks write, write outranks read; nothing is accepted while clearing.
  assign w_wr = !w_busy && !clr_i && wr_en_i;
  assign w_rd = !w_busy && !clr_i && !wr_en_i && rd_en_i;

  always_ff @(posedge clk_i) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_wr) begin
      for (int unsigned k = 0; k < BE_BIT; k++) begin
        if (be_i[k]) r_mem[addr_i][8*k +: 8] <= di_i[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_rd) r_rdata <= r_mem[addr_i];
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_rd_valid <= 1'b0;
    else        r_rd_valid <= w_rd;
  end

  assign do_o       = r_rd_valid ? r_rdata : IDLE_VAL;
  assign rd_valid_o = r_rd_valid;
  assign busy_o     = w_busy;

`ifdef USER_RAM_PARITY_EN
  logic [BE_BIT-1:0] r_par [DEPTH];
  logic [BE_BIT-1:0] w_rd_par;
  logic              r_par_err;

  always_ff @(posedge clk_i) begin
    if (w_clr_we) begin
      r_par[w_clr_addr] <= '0;
    end else if (w_wr) begin
      for (int unsigned k = 0; k < BE_BIT; k++) begin
        if (be_i[k]) r_par[addr_i][k] <= byte_parity(di_i[8*k +: 8]);
      end
    end
  end

  always_comb begin
    w_rd_par = '0;
    for (int unsigned k = 0; k < BE_BIT; k++) begin
      w_rd_par[k] = byte_parity(r_mem[addr_i][8*k +: 8]);
    end
  end

  // Check is done at read acceptance so the flag lines up with the read data.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_par_err <= 1'b0;
    else        r_par_err <= w_rd && (|(w_rd_par ^ r_par[addr_i]));
  end

  assign par_err_o = r_par_err;
`else
  assign par_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_user_ram_ctrl.sv
// Self-checking bench for user_ram_ctrl: behavioural memory model plus directed vectors.
module tb_user_ram_ctrl;

  localparam int DEPTH = 256;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic        clr   = 1'b0;
  logic [3:0]  be    = '0;
  logic [7:0]  addr  = '0;
  logic [31:0] di    = '0;
  logic [31:0] do_o;
  logic        rd_valid;
  logic        busy;
  logic        par_err;

  int total = 0;
  int bad   = 0;

  user_ram_ctrl #(
    .ADDR_BIT (8),
    .DATA_BIT (32)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .wr_en_i    (wr_en),
    .rd_en_i    (rd_en),
    .be_i       (be),
    .addr_i     (addr),
    .di_i       (di),
    .clr_i      (clr),
    .do_o       (do_o),
    .rd_valid_o (rd_valid),
    .busy_o     (busy),
    .par_err_o  (par_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: remaining clear cycles, word array, and the one-cycle read result.
  logic [31:0] m_mem [DEPTH];
  bit          m_corrupt [DEPTH];
  int          busy_left = DEPTH;
  logic        m_valid   = 1'b0;
  logic        m_perr    = 1'b0;
  logic [31:0] m_data    = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_left = DEPTH;
      m_valid   = 1'b0;
      m_perr    = 1'b0;
    end else if (busy_left > 0) begin
      m_mem[DEPTH - busy_left]     = '0;
      m_corrupt[DEPTH - busy_left] = 1'b0;
      busy_left--;
      m_valid = 1'b0;
      m_perr  = 1'b0;
    end else if (clr) begin
      busy_left = DEPTH;
      m_valid   = 1'b0;
      m_perr    = 1'b0;
    end else if (wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) begin
          m_mem[addr][8*k +: 8] = di[8*k +: 8];
          if (k == 0) m_corrupt[addr] = 1'b0;
        end
      end
      m_valid = 1'b0;
      m_perr  = 1'b0;
    end else if (rd_en) begin
      m_valid = 1'b1;
      m_data  = m_mem[addr];
      m_perr  = m_corrupt[addr];
    end else begin
      m_valid = 1'b0;
      m_perr  = 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("busy",  {31'b0, busy},     {31'b0, (busy_left > 0)});
    chk("valid", {31'b0, rd_valid}, {31'b0, m_valid});
    chk("do",    do_o,              m_valid ? m_data : 32'h1);
    chk("perr",  {31'b0, par_err},  {31'b0, m_perr});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
    be = '0; addr = '0; di = '0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] b);
    wr_en = 1'b1; addr = a; di = d; be = b;
    step();
    idle_in();
  endtask

  task automatic do_read(input logic [7:0] a, input logic [31:0] exp, input string name);
    rd_en = 1'b1; addr = a;
    step();
    rd_en = 1'b0;
    chk(name, do_o, exp);
    chk({name, "_valid"}, {31'b0, rd_valid}, 32'h1);
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (busy && n < 400) begin
      step();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    idle_in();
    repeat (3) step();
    chk("rst_busy",  {31'b0, busy},     32'h1);
    chk("rst_valid", {31'b0, rd_valid}, 32'h0);
    chk("rst_do",    do_o,              32'h1);
    rst_n = 1'b1;
    wait_busy(n);
    chk("init_clear_len", n, 256);

    do_read(8'd10, 32'h0, "rd_after_init");
    step();
    chk("idle_do",    do_o,              32'h1);
    chk("idle_valid", {31'b0, rd_valid}, 32'h0);

    do_write(8'd5, 32'hDEADBEEF, 4'hF);
    do_read(8'd5, 32'hDEADBEEF, "rd_full");
    do_write(8'd5, 32'h00001100, 4'b0010);
    do_read(8'd5, 32'hDEAD11EF, "rd_partial");

    rd_en = 1'b1; addr = 8'd5;
    step();
    chk("b2b_0", do_o, 32'hDEAD11EF);
    addr = 8'd10;
    step();
    chk("b2b_1", do_o, 32'h0);
    chk("b2b_1_valid", {31'b0, rd_valid}, 32'h1);
    idle_in();

    wr_en = 1'b1; rd_en = 1'b1; addr = 8'd5; be = 4'h0; di = 32'hFFFFFFFF;
    step();
    idle_in();
    chk("be0_blocks_rd", {31'b0, rd_valid}, 32'h0);
    do_read(8'd5, 32'hDEAD11EF, "be0_noop");

    wr_en = 1'b1; rd_en = 1'b1; addr = 8'd3; be = 4'hF; di = 32'h12345678;
    step();
    idle_in();
    chk("wr_rd_valid", {31'b0, rd_valid}, 32'h0);
    do_read(8'd3, 32'h12345678, "wr_rd_data");

`ifdef USER_RAM_PARITY_EN
    dut.r_mem[7] = dut.r_mem[7] ^ 32'h1;
    m_mem[7]     = m_mem[7] ^ 32'h1;
    m_corrupt[7] = 1'b1;
    do_read(8'd7, 32'h1, "par_rd7");
    chk("par_err7", {31'b0, par_err}, 32'h1);
    do_read(8'd8, 32'h0, "par_rd8");
    chk("par_err8", {31'b0, par_err}, 32'h0);
`endif

    clr = 1'b1;
    step();
    idle_in();
    wait_busy(n);
    chk("clr_len", n, 256);
    do_read(8'd3, 32'h0, "after_clr");

    do_write(8'd5, 32'hCAFEF00D, 4'hF);
    clr = 1'b1; wr_en = 1'b1; addr = 8'd5; be = 4'hF; di = 32'h55555555;
    step();
    idle_in();
    chk("clr_busy", {31'b0, busy}, 32'h1);
    for (int i = 0; i < 100; i++) begin
      wr_en = 1'b1; rd_en = 1'b1; addr = 8'(i + 100); be = 4'hF; di = 32'hAAAA5555;
      step();
    end
    idle_in();
    chk("mid_busy", {31'b0, busy}, 32'h1);
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    wait_busy(n);
    chk("restart_len", n, 256);

    for (int i = 0; i < DEPTH; i++) begin
      do_read(8'(i), 32'h0, "zero_scan");
    end
    step();
    chk("end_idle_do", do_o, 32'h1);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
